// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Pure definitions; no logic, latency or flow control here.
package muldiv_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
// Combinational, zero latency; no flow control.
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     operand,
  input  logic                  in_bit,
  output logic [2*DATA_W-1:0]   acc_next,
  output logic                  q_bit
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;

  // Divide keeps {remainder, quotient}; the next dividend bit enters the remainder LSB.
  assign rem_sh = {acc[2*DATA_W-1:DATA_W], in_bit};
  assign diff   = rem_sh[DATA_W-1:0] - operand;

  always_comb begin
    q_bit    = 1'b0;
    acc_next = '0;
    if (is_div) begin
      q_bit    = (rem_sh >= {1'b0, operand});
      acc_next = {(q_bit ? diff : rem_sh[DATA_W-1:0]), acc[DATA_W-2:0], 1'b0};
    end else begin
      acc_next = {acc[2*DATA_W-2:0], 1'b0}
               + (in_bit ? {{DATA_W{1'b0}}, operand} : {(2*DATA_W){1'b0}});
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO; done pulses DATA_W+2 cycles after start.
// No backpressure: start is honoured only in IDLE, busy stalls the pipeline, flush aborts.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic                sign_a_q, sign_b_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [2*DATA_W-1:0] acc_q, acc_step, acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                q_bit;

  logic                neg_a, neg_b, diff_sign;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rem, hi_fix, lo_fix;

  assign neg_a = op[0] & a[DATA_W-1];
  assign neg_b = op[0] & b[DATA_W-1];

  // opa_q shifts left each RUN cycle, feeding multiplier / dividend bits MSB first.
  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div   (op_q[1]),
    .acc      (acc_q),
    .operand  (opb_q),
    .in_bit   (opa_q[DATA_W-1]),
    .acc_next (acc_step),
    .q_bit    (q_bit)
  );

  // The step leaves the LSB free on divide; the quotient bit lands there.
  assign acc_d = acc_step | {{(2*DATA_W-1){1'b0}}, q_bit};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !flush) state_d = RUN;
      RUN: begin
        if (flush)              state_d = IDLE;
        else if (cnt_q == LAST) state_d = FIX;
      end
      FIX:     state_d = flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign fixup; sign bits are only ever latched for signed ops.
  always_comb begin
    diff_sign = sign_a_q ^ sign_b_q;
    prod      = diff_sign ? -acc_q : acc_q;
    quo       = acc_q[DATA_W-1:0];
    rem       = acc_q[2*DATA_W-1:DATA_W];
    hi_fix    = prod[2*DATA_W-1:DATA_W];
    lo_fix    = prod[DATA_W-1:0];
    if (op_q[1]) begin
      hi_fix = sign_a_q ? -rem : rem;
      lo_fix = (opb_q == '0) ? '1 : (diff_sign ? -quo : quo);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            op_q     <= op;
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            opa_q    <= neg_a ? -a : a;
            opb_q    <= neg_b ? -b : b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          opa_q <= opa_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          if (!flush) begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomised bench for hilo_muldiv_unit with an expected-result queue.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      OP_MULTU: res = {32'b0, x} * {32'b0, y};
      OP_MULT:  res = 64'(sx * sy);
      OP_DIVU:  res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Presents start for one edge; returns at the sample point of cycle 1.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int cyc, output logic [47:0] trace);
    logic [63:0] exp;
    cyc   = 1;
    trace = '0;
    trace[1] = busy;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      trace[cyc] = busy;
    end
    exp = exp_q.pop_front();
    check({tag, " done_cycle"}, 64'(cyc), 64'd34);
    check({tag, " hilo"}, {hi, lo}, exp);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    int cyc;
    logic [47:0] trace;
    exp_q.push_back(exp);
    start_op(o, x, y);
    wait_result(tag, cyc, trace);
  endtask

  initial begin
    int          cyc;
    logic [47:0] trace;
    logic        saw_done;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("reset busy_done", {62'b0, busy, done}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Latency and busy profile on the first operation.
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", cyc, trace);
    check("multu_max busy_trace", 64'(trace), 64'h3_FFFF_FFFE);

    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("mult_minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // Stray start mid-run, then flush: no result, hi/lo keep the overflow result.
    start_op(OP_MULTU, 32'd3, 32'd4);
    repeat (8) begin @(posedge clk); #1; end
    start = 1'b1; a = 32'd100; b = 32'd200;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_stray_start", {63'b0, busy}, 64'd1);
    repeat (9) begin @(posedge clk); #1; end
    check("busy_before_flush", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("busy_after_flush", {63'b0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_flush", {63'b0, saw_done}, 64'd0);
    check("hilo_held_after_flush", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 64'd12);

    // Asynchronous reset between edges in the middle of RUN.
    start_op(OP_MULTU, 32'd5, 32'd6);
    repeat (4) begin @(posedge clk); #1; end
    check("busy_before_reset", {63'b0, busy}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset busy_done", {62'b0, busy, done}, 64'd0);
    check("async_reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // start and flush together in IDLE: flush wins.
    @(negedge clk);
    op = OP_MULTU; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    check("start_flush next busy_done", {62'b0, busy, done}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i % 4);
      rx = (i == 6) ? 32'h8000_0000 : $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i == 7) ry = 32'h8000_0000;
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry, ref_model(ro, rx, ry));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit hanging off the execute stage of the pipelined core.
- Consumes MULT/MULTU/DIV/DIVU operands, with `rs` as `a` and `rt` as `b`.
- Produces the 64-bit HI/LO result consumed by the HILO register write (`we_hilo`).
- Exposes `busy` and `done` so the hazard logic can stall MFHI/MFLO and later mul/div ops while it runs.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  DATA_W  multiplicand / dividend (`rs`).
- b  input  DATA_W  multiplier / divisor (`rt`).
- flush  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  operation in progress; the hazard unit stalls on it.
- done  output  1  single-cycle pulse; `hi`/`lo` are valid from that cycle onward.
- hi  output  DATA_W  MULT: upper product word. DIV: remainder.
- lo  output  DATA_W  MULT: lower product word. DIV: quotient.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, hi=0, lo=0; all internal registers cleared. Reset mid-operation discards the operation.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: on start=1 and flush=0, latch `op`. Signed ops latch |a|, |b| and the two sign bits; unsigned ops latch `a`, `b` raw. Clear the 2*DATA_W accumulator and iteration counter; go to RUN.
- RUN:
  - Exactly DATA_W cycles, one bit per cycle.
  - Multiply: shift-add on the magnitude product.
  - Divide: restoring shift-subtract; the quotient bit is set when the trial subtraction is non-negative.
  - Counter 0..DATA_W-1; at DATA_W-1 go to FIX.
- FIX (1 cycle): apply sign correction for signed ops.
  - MULT: negate the 64-bit product if sign(a) XOR sign(b).
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Register the results into hi/lo; go to DONE.
- DONE (1 cycle): done=1; go to IDLE. A start in DONE is ignored; it must be presented in IDLE.
- busy=1 in RUN and FIX; busy=0 in IDLE and DONE.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+DATA_W+2 (34 cycles for DATA_W=32). Back-to-back throughput is one operation per DATA_W+3 cycles.
- hi/lo change only on the FIX->DONE transfer and hold otherwise, including across flush and later starts.
- start while busy: ignored, no effect.
- flush in RUN/FIX: next state IDLE; no done pulse; hi/lo unchanged.
- flush in DONE: done still pulses this cycle and hi/lo stand.
- start and flush in the same IDLE cycle: flush wins; start dropped.
- Divide by zero (DIVU or DIV): lo = all ones, hi = a unmodified. No trap.
- Signed overflow, DIV of most-negative by -1: lo = most-negative (two's-complement wrap), hi=0.
- Magnitude of the most-negative operand: treated as the unsigned value 2^(DATA_W-1). The datapath must not lose that bit.
- All arithmetic wraps modulo 2^DATA_W per word. No X may propagate to outputs from any reachable state.

Decomposition:
- Shared package `muldiv_pkg`:
  - op encodings: OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11.
  - FSM state encoding: IDLE, RUN, FIX, DONE.
  - DATA_W default.
- One sub-module, `muldiv_step`: combinational single-iteration datapath. It takes op class, accumulator and operand, and returns the next accumulator plus quotient bit. FSM, counter and sign fixup stay in the top.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done high exactly 34 cycles after the start edge; busy high for cycles 1..33.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. Then MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. Then DIVU a=7 b=0 -> lo=0xFFFFFFFF hi=0x00000007.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- Start MULTU 3*4; at cycle 10 pulse start with new operands (ignored); at cycle 20 assert flush -> busy=0 next cycle, no done, hi/lo keep prior values. Then MULTU 3*4 runs clean -> lo=12 hi=0.
- Assert rst mid-RUN (asynchronous, between edges) -> busy, done, hi, lo all 0 immediately. Start and flush together in IDLE -> stays IDLE, busy=0.
